// File: rtl/non_fast_pattern_match_extractor.sv
// Serialises zero bits of each shift-or beat into (byte offset, bucket) match records plus an eop marker.
// First record 1 cycle after accept, then 1/cycle; output register holds under backpressure and in_ready drops.
module non_fast_pattern_match_extractor #(
    parameter int DWIDTH = 128,
    parameter int OFFW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_match,
    output logic [OFFW-1:0]   out_pos,
    output logic [2:0]        out_bucket,
    output logic              out_eop
);

    localparam int BYTES = DWIDTH / 8;
    localparam int IW    = $clog2(DWIDTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DWIDTH-1:0] r_pending;
    logic [OFFW-1:0]   r_base;
    logic              r_eop_l;
    logic              r_started;

    logic              w_slot_free;
    logic              w_accept;
    logic              w_emit;
    logic [IW-1:0]     w_idx;
    logic [DWIDTH-1:0] w_pend_clr;

    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = (r_state == IDLE) && w_slot_free;
    assign w_accept    = in_valid && in_ready;
    // Clearing the lowest set bit also tells us whether this is the final record.
    assign w_pend_clr  = r_pending & (r_pending - 1'b1);

    always_comb begin
        w_idx = '0;
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = IW'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (((~in_data) != '0) || in_eop)) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_slot_free) begin
                    w_emit = 1'b1;
                    if (w_pend_clr == '0) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_base     <= '0;
            r_eop_l    <= 1'b0;
            r_started  <= 1'b0;
            out_valid  <= 1'b0;
            out_match  <= 1'b0;
            out_pos    <= '0;
            out_bucket <= '0;
            out_eop    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= ~in_data;
                r_eop_l   <= in_eop;
                r_started <= 1'b1;
                // A beat with no sop straight after reset is treated as starting at offset 0.
                r_base    <= (in_sop || !r_started) ? '0 : r_base + OFFW'(BYTES);
            end else if (w_emit) begin
                r_pending <= w_pend_clr;
            end

            if (w_emit) begin
                out_valid <= 1'b1;
                if (r_pending != '0) begin
                    out_match  <= 1'b1;
                    out_pos    <= r_base + OFFW'(w_idx >> 3);
                    out_bucket <= w_idx[2:0];
                    out_eop    <= r_eop_l && (w_pend_clr == '0);
                end else begin
                    out_match  <= 1'b0;
                    out_pos    <= r_base;
                    out_bucket <= '0;
                    out_eop    <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_non_fast_pattern_match_extractor.sv
// Directed bench for the match extractor: hand-computed records checked at the falling edge.
module tb_non_fast_pattern_match_extractor;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_sop;
    logic         in_eop;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic         out_match;
    logic [15:0]  out_pos;
    logic [2:0]   out_bucket;
    logic         out_eop;

    int checks   = 0;
    int failures = 0;
    logic [21:0] obs;

    always #5 clk = ~clk;

    non_fast_pattern_match_extractor #(.DWIDTH(128), .OFFW(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
        .out_pos(out_pos), .out_bucket(out_bucket), .out_eop(out_eop)
    );

    // {valid, match, pos, bucket, eop}
    always_comb obs = {out_valid, out_match, out_pos, out_bucket, out_eop};

    // Call at a falling edge; returns 1ns after the accepting rising edge.
    task automatic send_beat(input logic [127:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_beat_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] d;
        rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 22'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state rec=%h in_ready=%b required rec=0 in_ready=1", obs, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        d = '1; d[10] = 1'b0;
        send_beat(d, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd1, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL first_beat_no_sop rec=%h required=%h", obs, {1'b1, 1'b1, 16'd1, 3'd2, 1'b1});
        end
    endtask

    task automatic test_two_matches();
        logic [127:0] d;
        d = '1; d[0] = 1'b0; d[17] = 1'b0;
        @(negedge clk);
        send_beat(d, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL two_latency out_valid=%b required=0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL two_rec0 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd0, 3'd0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd2, 3'd1, 1'b1} || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL two_rec1 rec=%h in_ready=%b required rec=%h in_ready=1", obs, in_ready,
                     {1'b1, 1'b1, 16'd2, 3'd1, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL two_drain out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_empty_packet();
        @(negedge clk);
        send_beat('1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_beat1 out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        send_beat('1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL empty_beat2 out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        send_beat('1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b0, 16'd32, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL empty_marker rec=%h required=%h", obs, {1'b1, 1'b0, 16'd32, 3'd0, 1'b1});
        end
    endtask

    task automatic test_second_beat();
        logic [127:0] d;
        d = '1; d[127] = 1'b0;
        @(negedge clk);
        send_beat('1, 1'b1, 1'b0);
        @(negedge clk);
        send_beat(d, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd31, 3'd7, 1'b1}) begin
            failures++;
            $display("FAIL beat2_bit127 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd31, 3'd7, 1'b1});
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        d = '1; d[3] = 1'b0; d[9] = 1'b0; d[40] = 1'b0; d[127] = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(d, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd0, 3'd3, 1'b0}) begin
            failures++;
            $display("FAIL bp_rec0 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd0, 3'd3, 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== {1'b1, 1'b1, 16'd0, 3'd3, 1'b0} || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d rec=%h in_ready=%b required rec=%h in_ready=0", k, obs, in_ready,
                         {1'b1, 1'b1, 16'd0, 3'd3, 1'b0});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd1, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL bp_rec1 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd1, 3'd1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd5, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL bp_rec2 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd5, 3'd0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd15, 3'd7, 1'b1}) begin
            failures++;
            $display("FAIL bp_rec3 rec=%h required=%h", obs, {1'b1, 1'b1, 16'd15, 3'd7, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_sop_restart();
        logic [127:0] d;
        d = '1; d[8] = 1'b0;
        @(negedge clk);
        send_beat('1, 1'b1, 1'b0);
        @(negedge clk);
        send_beat('1, 1'b0, 1'b0);
        @(negedge clk);
        send_beat(d, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd1, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL sop_restart rec=%h required=%h", obs, {1'b1, 1'b1, 16'd1, 3'd0, 1'b1});
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [127:0] d;
        d = '1; d[0] = 1'b0; d[1] = 1'b0; d[2] = 1'b0; d[3] = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(d, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL rst_pre rec=%h required=%h", obs, {1'b1, 1'b1, 16'd0, 3'd0, 1'b0});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 22'd0) begin
            failures++;
            $display("FAIL rst_async rec=%h required=0", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_no_stale out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        d = '1; d[5] = 1'b0;
        send_beat(d, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 1'b1, 16'd0, 3'd5, 1'b1}) begin
            failures++;
            $display("FAIL rst_after rec=%h required=%h", obs, {1'b1, 1'b1, 16'd0, 3'd5, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_drain out_valid=%b required=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_two_matches();
        test_empty_packet();
        test_second_beat();
        test_backpressure();
        test_sop_restart();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
